dmem_bridge: RTL and testbench

- Data-memory bridge directly downstream of the execute-stage memory unit.
- Accepts that unit's strobe-based requests and converts them into aligned 64-bit transactions with byte enables on the data bus.
- Returns read data left-justified and raises a one-cycle completion pulse.
- Detects misalignment, out-of-range addresses and bus timeouts, and reports each as an error completion.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/dmem_lane_align.sv | 40 ++++
 rtl/dmem_bridge.sv | 157 +++++++++++++++
 tb/tb_dmem_bridge.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the data-memory bridge.
// Width codes follow the memory unit's 2-bit size field (0 = 64b ... 3 = 8b).
package mem_pkg;

  typedef enum logic [1:0] {
    W64 = 2'd0,
    W32 = 2'd1,
    W16 = 2'd2,
    W8  = 2'd3
  } width_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [3:0] byte_count(input logic [1:0] width);
    return 4'd8 >> width;
  endfunction

  // An access is aligned when its byte offset is a multiple of its size.
  function automatic logic is_aligned(input logic [2:0] k, input logic [1:0] width);
    logic [3:0] n;
    n = byte_count(width);
    return ({1'b0, k} & (n - 4'd1)) == 4'd0;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering: byte enables, lane-positioned store data and
// left-justified load data from byte offset k and access width.
module dmem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  k,
  input  logic [1:0]  width,
  input  logic [63:0] store_data,
  input  logic [63:0] rdata,
  output logic [7:0]  be,
  output logic [63:0] wdata,
  output logic [63:0] rdata_left
);

  logic [3:0]  n;
  logic [3:0]  span;
  logic [63:0] store_mask;

  always_comb begin
    n = byte_count(width);
    // Bytes below the access in lane order; only meaningful for aligned accesses.
    span = 4'd8 - {1'b0, k} - n;

    case (width)
      W64:     store_mask = '1;
      W32:     store_mask = 64'h0000_0000_FFFF_FFFF;
      W16:     store_mask = 64'h0000_0000_0000_FFFF;
      default: store_mask = 64'h0000_0000_0000_00FF;
    endcase

    be = '0;
    for (int i = 0; i < 8; i++) begin
      be[i] = (4'(i) >= {1'b0, k}) && (4'(i) < ({1'b0, k} + n));
    end

    wdata      = (store_data & store_mask) << {span[2:0], 3'b000};
    rdata_left = rdata << {k, 3'b000};
  end

endmodule

// File: rtl/dmem_bridge.sv
// Converts strobe-based memory-unit requests into aligned 64-bit bus
// transactions; faults (misalignment, range, timeout) complete with error.
module dmem_bridge
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       dmem_addr,
  input  logic [63:0]       dmem_dout,
  input  logic [1:0]        dmem_width,
  input  logic              dmem_rstrobe,
  input  logic              dmem_wstrobe,
  output logic [63:0]       dmem_din,
  output logic              dmem_cycle_complete,
  output logic              dmem_error,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_be,
  output logic [63:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [63:0]       bus_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        width_q;
  logic [63:0]       wdat_q;
  logic              we_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [63:0]       din_q;

  logic        strobe, in_range, legal, timeout_hit;
  logic        accept, fail, cap;
  logic [7:0]  lane_be;
  logic [63:0] lane_wdata, lane_rdata;

  if (ADDR_W < 64) begin : g_rng
    assign in_range = ~|dmem_addr[63:ADDR_W];
  end else begin : g_full
    assign in_range = 1'b1;
  end

  assign strobe      = dmem_rstrobe | dmem_wstrobe;
  assign legal       = is_aligned(dmem_addr[2:0], dmem_width) && in_range &&
                       !(dmem_rstrobe && dmem_wstrobe);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  dmem_lane_align u_align (
    .k          (addr_q[2:0]),
    .width      (width_q),
    .store_data (wdat_q),
    .rdata      (bus_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .rdata_left (lane_rdata)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    fail    = 1'b0;
    cap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          accept = 1'b1;
          if (legal) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_DONE;
            fail    = 1'b1;
          end
        end
      end
      ST_REQ: begin
        // A grant in the last allowed cycle still wins over the timeout.
        if (bus_gnt) begin
          if (we_q) begin
            state_d = ST_DONE;
          end else if (bus_rvalid) begin
            state_d = ST_DONE;
            cap     = 1'b1;
          end else begin
            state_d = ST_RESP;
          end
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          fail    = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus_rvalid) begin
          state_d = ST_DONE;
          cap     = 1'b1;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          fail    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      width_q <= '0;
      wdat_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= dmem_addr[ADDR_W-1:0];
        width_q <= dmem_width;
        wdat_q  <= dmem_dout;
        we_q    <= dmem_wstrobe;
        cnt_q   <= '0;
      end else if (state_q == ST_REQ || state_q == ST_RESP) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (accept || fail) err_q <= fail;
      if (fail)     din_q <= '0;
      else if (cap) din_q <= lane_rdata;
    end
  end

  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = '0;
    bus_wdata = '0;
    if (state_q == ST_REQ) begin
      bus_req   = 1'b1;
      bus_we    = we_q;
      bus_addr  = {addr_q[ADDR_W-1:3], 3'b000};
      bus_be    = lane_be;
      bus_wdata = we_q ? lane_wdata : 64'd0;
    end
  end

  assign dmem_din            = din_q;
  assign dmem_cycle_complete = (state_q == ST_DONE);
  assign dmem_error          = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: completions are scored against a queue of
// expected (cycle, error, data) entries pushed when each request is issued.
module tb_dmem_bridge;
  import mem_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [63:0]       dmem_addr, dmem_dout, dmem_din, bus_wdata, bus_rdata;
  logic [1:0]        dmem_width;
  logic              dmem_rstrobe, dmem_wstrobe, dmem_cycle_complete, dmem_error;
  logic              bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_be;

  always #5 clk = ~clk;

  dmem_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dmem_addr           (dmem_addr),
    .dmem_dout           (dmem_dout),
    .dmem_width          (dmem_width),
    .dmem_rstrobe        (dmem_rstrobe),
    .dmem_wstrobe        (dmem_wstrobe),
    .dmem_din            (dmem_din),
    .dmem_cycle_complete (dmem_cycle_complete),
    .dmem_error          (dmem_error),
    .bus_req             (bus_req),
    .bus_we              (bus_we),
    .bus_addr            (bus_addr),
    .bus_be              (bus_be),
    .bus_wdata           (bus_wdata),
    .bus_gnt             (bus_gnt),
    .bus_rvalid          (bus_rvalid),
    .bus_rdata           (bus_rdata)
  );

  typedef struct {
    logic        err;
    logic [63:0] din;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   t0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_cpl(input logic err, input logic [63:0] din, input int c);
    exp_t e;
    e.err = err;
    e.din = din;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [63:0] a, input logic [1:0] w, input logic [63:0] d,
                       input logic r, input logic wr);
    dmem_addr    = a;
    dmem_width   = w;
    dmem_dout    = d;
    dmem_rstrobe = r;
    dmem_wstrobe = wr;
  endtask

  task automatic tick();
    @(negedge clk);
    dmem_rstrobe = 1'b0;
    dmem_wstrobe = 1'b0;
  endtask

  // Completion monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && dmem_cycle_complete) begin
      if (sb.size() == 0) begin
        chk("spurious_cpl", 64'(dmem_cycle_complete), 64'd0);
      end else begin
        got_e = sb.pop_front();
        chk("cpl_cycle", 64'(cyc), 64'(got_e.cyc));
        chk("cpl_err", 64'(dmem_error), 64'(got_e.err));
        chk("cpl_din", dmem_din, got_e.din);
      end
    end
  end

  initial begin
    issue(64'd0, W64, 64'd0, 1'b0, 1'b0);
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 64'd0;
    repeat (2) @(negedge clk);
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_din", dmem_din, 64'd0);
    chk("rst_cpl", 64'(dmem_cycle_complete), 64'd0);
    rst_n = 1'b1;
    tick();

    // Aligned 64b read, grant at T+1, data at T+3.
    t0 = cyc;
    issue(64'h1000, W64, 64'd0, 1'b1, 1'b0);
    expect_cpl(1'b0, 64'h0123456789ABCDEF, t0 + 4);
    tick();
    chk("rd64_req", 64'(bus_req), 64'd1);
    chk("rd64_addr", 64'(bus_addr), 64'h1000);
    chk("rd64_be", 64'(bus_be), 64'hFF);
    chk("rd64_we", 64'(bus_we), 64'd0);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk("rd64_req_dropped", 64'(bus_req), 64'd0);
    tick();
    bus_rvalid = 1'b1;
    bus_rdata  = 64'h0123456789ABCDEF;
    tick();
    bus_rvalid = 1'b0;
    bus_rdata  = 64'd0;
    tick();

    // Byte read at offset 5 with data in the grant cycle.
    t0 = cyc;
    issue(64'h1005, W8, 64'd0, 1'b1, 1'b0);
    expect_cpl(1'b0, 64'h5566770000000000, t0 + 2);
    tick();
    chk("rd8_addr", 64'(bus_addr), 64'h1000);
    chk("rd8_be", 64'(bus_be), 64'h20);
    bus_gnt    = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata  = 64'h0011223344556677;
    tick();
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 64'd0;
    chk("rd8_byte", 64'(dmem_din[63:56]), 64'h55);
    tick();

    // 16b write at offset 2, immediate grant; din must be left untouched.
    t0 = cyc;
    issue(64'h2002, W16, 64'h000000000000BEEF, 1'b0, 1'b1);
    expect_cpl(1'b0, 64'h5566770000000000, t0 + 2);
    tick();
    chk("wr16_addr", 64'(bus_addr), 64'h2000);
    chk("wr16_we", 64'(bus_we), 64'd1);
    chk("wr16_be", 64'(bus_be), 64'h0C);
    chk("wr16_wdata", bus_wdata, 64'h0000BEEF00000000);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    tick();

    // 32b write at offset 4 with a late grant; a strobe while busy is ignored.
    t0 = cyc;
    issue(64'h0014, W32, 64'h00000000CAFEF00D, 1'b0, 1'b1);
    expect_cpl(1'b0, 64'h5566770000000000, t0 + 3);
    tick();
    chk("wr32_be", 64'(bus_be), 64'hF0);
    chk("wr32_wdata", bus_wdata, 64'h00000000CAFEF00D);
    issue(64'h3000, W64, 64'd0, 1'b1, 1'b0);
    tick();
    chk("wr32_hold_req", 64'(bus_req), 64'd1);
    chk("wr32_hold_addr", 64'(bus_addr), 64'h10);
    chk("wr32_hold_be", 64'(bus_be), 64'hF0);
    chk("wr32_hold_wdata", bus_wdata, 64'h00000000CAFEF00D);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    tick();

    // Misaligned, out-of-range and dual-strobe requests: error, no bus cycle.
    t0 = cyc;
    issue(64'h3002, W32, 64'd0, 1'b1, 1'b0);
    expect_cpl(1'b1, 64'd0, t0 + 1);
    tick();
    chk("misalign_no_req", 64'(bus_req), 64'd0);
    tick();
    t0 = cyc;
    issue(64'h1_0000_0000, W64, 64'd0, 1'b1, 1'b0);
    expect_cpl(1'b1, 64'd0, t0 + 1);
    tick();
    chk("range_no_req", 64'(bus_req), 64'd0);
    tick();
    t0 = cyc;
    issue(64'h0100, W64, 64'd0, 1'b1, 1'b1);
    expect_cpl(1'b1, 64'd0, t0 + 1);
    tick();
    chk("both_no_req", 64'(bus_req), 64'd0);
    tick();

    // Timeout: grant never comes; late rvalid afterwards must be ignored.
    t0 = cyc;
    issue(64'h4000, W64, 64'd0, 1'b1, 1'b0);
    expect_cpl(1'b1, 64'd0, t0 + 5);
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      chk("tmo_req_held", 64'(bus_req), 64'd1);
    end
    tick();
    chk("tmo_req_dropped", 64'(bus_req), 64'd0);
    bus_rvalid = 1'b1;
    bus_rdata  = 64'hDEADDEADDEADDEAD;
    tick();
    tick();
    bus_rvalid = 1'b0;
    bus_rdata  = 64'd0;
    chk("late_rvalid_din", dmem_din, 64'd0);
    tick();
    t0 = cyc;
    issue(64'h4008, W64, 64'd0, 1'b1, 1'b0);
    expect_cpl(1'b0, 64'hFEEDFACE01020304, t0 + 3);
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 64'hFEEDFACE01020304;
    tick();
    bus_rvalid = 1'b0;
    bus_rdata  = 64'd0;
    tick();

    // Reset while waiting for read data, then a fresh byte write.
    issue(64'h5000, W64, 64'd0, 1'b1, 1'b0);
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(bus_req), 64'd0);
    chk("mid_rst_we", 64'(bus_we), 64'd0);
    chk("mid_rst_addr", 64'(bus_addr), 64'd0);
    chk("mid_rst_be", 64'(bus_be), 64'd0);
    chk("mid_rst_wdata", bus_wdata, 64'd0);
    chk("mid_rst_din", dmem_din, 64'd0);
    chk("mid_rst_cpl", 64'(dmem_cycle_complete), 64'd0);
    chk("mid_rst_err", 64'(dmem_error), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    t0 = cyc;
    issue(64'h6000, W8, 64'h00000000000000AB, 1'b0, 1'b1);
    expect_cpl(1'b0, 64'd0, t0 + 2);
    tick();
    chk("post_rst_be", 64'(bus_be), 64'h01);
    chk("post_rst_wdata", bus_wdata, 64'hAB00000000000000);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    repeat (3) tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
